// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the HH:MM clock time-set path.
//   state_t        : set-mode FSM state encoding
//   HR_MAX_T ...   : BCD digit limits used when stepping a field
//   bcd_wrap_inc   : step one BCD digit, wrapping to 0 past a limit
//   hour_inc       : step the hour pair 00..23 as a unit
// No ports (package).
// ---------------------------------------------------------------------------
package clock_pkg;

   typedef enum logic [2:0] {
      RUN    = 3'd0,
      SET_HR = 3'd1,
      SET_MT = 3'd2,
      SET_MU = 3'd3,
      COMMIT = 3'd4
   } state_t;

   localparam logic [3:0] HR_MAX_T      = 4'd2;
   localparam logic [3:0] HR_MAX_U_AT_2 = 4'd3;
   localparam logic [3:0] MIN_MAX_T     = 4'd5;
   localparam logic [3:0] DIG_MAX       = 4'd9;

   // Step a single digit; anything at or above the limit wraps to 0 so an
   // out-of-range captured value still recovers on the next press.
   function automatic logic [3:0] bcd_wrap_inc(input logic [3:0] d,
                                               input logic [3:0] maxV);
      return (d >= maxV) ? 4'd0 : d + 4'd1;
   endfunction

   // The hour is stepped as a pair: units carry into tens, and 23 wraps to 00.
   function automatic logic [7:0] hour_inc(input logic [3:0] t,
                                           input logic [3:0] u);
      if ((t >= HR_MAX_T) && (u >= HR_MAX_U_AT_2))
         return 8'h00;
      else if (u >= DIG_MAX)
         return {t + 4'd1, 4'd0};
      else
         return {t, u + 4'd1};
   endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl_if
// Bundles the time-set controller's button, tick, time and set-path signals.
//   master : system side (drives buttons, tick and current time, reads set path)
//   slave  : clock_set_ctrl side
// Signals:
//   btn_mode/btn_sel/btn_inc : raw TSW buttons, active-high
//   tick_1hz                 : one-cycle pulse per second
//   cur_h1..cur_m0           : current time BCD digits
//   run_en, load             : counter enable / one-cycle load strobe
//   set_h1..set_m0           : shadow BCD digits
//   blank                    : per-digit blank mask {h1,h0,m1,m0}
//   set_mode                 : high while setting the time
// ---------------------------------------------------------------------------
interface clock_set_ctrl_if;

   logic       btn_mode;
   logic       btn_sel;
   logic       btn_inc;
   logic       tick_1hz;
   logic [3:0] cur_h1;
   logic [3:0] cur_h0;
   logic [3:0] cur_m1;
   logic [3:0] cur_m0;
   logic       run_en;
   logic       load;
   logic [3:0] set_h1;
   logic [3:0] set_h0;
   logic [3:0] set_m1;
   logic [3:0] set_m0;
   logic [3:0] blank;
   logic       set_mode;

   modport master (
      output btn_mode, btn_sel, btn_inc, tick_1hz,
      output cur_h1, cur_h0, cur_m1, cur_m0,
      input  run_en, load, set_h1, set_h0, set_m1, set_m0, blank, set_mode
   );

   modport slave (
      input  btn_mode, btn_sel, btn_inc, tick_1hz,
      input  cur_h1, cur_h0, cur_m1, cur_m0,
      output run_en, load, set_h1, set_h0, set_m1, set_m0, blank, set_mode
   );

endinterface

// File: rtl/clock_set_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// tsw_debounce
// Debounces one raw TSW button and emits a one-cycle pulse on each accepted
// press.
// Parameters:
//   DB_CYCLES : cycles the synchronised input must differ from the accepted
//               level, without interruption, before it is taken
// Ports:
//   pCLK    in  system clock
//   pRST    in  asynchronous active-high reset
//   btn_i   in  raw button level
//   event_o out one-cycle pulse when the accepted level rises
// ---------------------------------------------------------------------------
module tsw_debounce #(
   parameter logic [15:0] DB_CYCLES = 16'd50000
) (
   input  logic pCLK,
   input  logic pRST,
   input  logic btn_i,
   output logic event_o
);

   logic        sync1_q;
   logic        sync2_q;
   logic        level_q;
   logic [15:0] cnt_q;
   logic        pulse_q;

   // Two-flop synchroniser. The stability counter only runs while the
   // synchronised input disagrees with the accepted level, so any bounce back
   // to the old level clears it and the next change starts a fresh count.
   always_ff @(posedge pCLK or posedge pRST) begin
      if (pRST) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         pulse_q <= 1'b0;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DB_CYCLES - 16'd1) begin
            cnt_q   <= '0;
            level_q <= sync2_q;
            pulse_q <= sync2_q;
         end else begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   assign event_o = pulse_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
// Time-set controller for the HH:MM clock. Debounces the three TSW buttons,
// runs the set-mode FSM over shadow copies of the time digits, and issues a
// one-cycle load into the time counters on commit. Counting is frozen while
// any set state is active; an idle timeout abandons the edit.
// Parameters:
//   DB_CYCLES   : debounce stability time in pCLK cycles
//   TIMEOUT_SEC : tick_1hz pulses without a button event before abort
//   BLINK_BIT   : blink divider bit that gates blanking (blink build only)
// Configuration macro:
//   CLKSET_BLINK_EN : when defined, the selected field blinks via blank;
//                     otherwise blank is constant 0 and there is no divider.
// Ports:
//   pCLK  in  system clock
//   pRST  in  asynchronous active-high reset
//   bus   clock_set_ctrl_if.slave : buttons, tick, current time, set path
// ---------------------------------------------------------------------------
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter logic [15:0] DB_CYCLES   = 16'd50000,
   parameter logic [7:0]  TIMEOUT_SEC = 8'd30
`ifdef CLKSET_BLINK_EN
   ,
   parameter logic [3:0]  BLINK_BIT   = 4'd9
`endif
) (
   input logic             pCLK,
   input logic             pRST,
   clock_set_ctrl_if.slave bus
);

   logic       modeEv;
   logic       selEv;
   logic       incEv;
   logic       timeoutHit;

   state_t     state_q, state_d;
   logic [3:0] setH1_q, setH1_d;
   logic [3:0] setH0_q, setH0_d;
   logic [3:0] setM1_q, setM1_d;
   logic [3:0] setM0_q, setM0_d;
   logic [7:0] idle_q, idle_d;
   logic [7:0] hourNext;

   tsw_debounce #(.DB_CYCLES(DB_CYCLES)) uDbMode (
      .pCLK    (pCLK),
      .pRST    (pRST),
      .btn_i   (bus.btn_mode),
      .event_o (modeEv)
   );

   tsw_debounce #(.DB_CYCLES(DB_CYCLES)) uDbSel (
      .pCLK    (pCLK),
      .pRST    (pRST),
      .btn_i   (bus.btn_sel),
      .event_o (selEv)
   );

   tsw_debounce #(.DB_CYCLES(DB_CYCLES)) uDbInc (
      .pCLK    (pCLK),
      .pRST    (pRST),
      .btn_i   (bus.btn_inc),
      .event_o (incEv)
   );

   // The tick that would push the idle count up to the limit is the expiry.
   assign timeoutHit = bus.tick_1hz && (idle_q == TIMEOUT_SEC - 8'd1);
   assign hourNext   = hour_inc(setH1_q, setH0_q);

   // State, shadow digits and idle counter. Reset clears everything at once,
   // which also means no load can be produced by a reset mid-edit.
   always_ff @(posedge pCLK or posedge pRST) begin
      if (pRST) begin
         state_q <= RUN;
         setH1_q <= 4'd0;
         setH0_q <= 4'd0;
         setM1_q <= 4'd0;
         setM0_q <= 4'd0;
         idle_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         setH1_q <= setH1_d;
         setH0_q <= setH0_d;
         setM1_q <= setM1_d;
         setM0_q <= setM0_d;
         idle_q  <= idle_d;
      end
   end

   // Next-state logic. Within one cycle mode beats timeout, timeout beats
   // sel, and sel beats inc; a losing event is simply discarded. Every
   // accepted button event in a set state restarts the idle count.
   always_comb begin
      state_d = state_q;
      setH1_d = setH1_q;
      setH0_d = setH0_q;
      setM1_d = setM1_q;
      setM0_d = setM0_q;
      idle_d  = idle_q;

      case (state_q)
         RUN: begin
            idle_d = 8'd0;
            if (modeEv) begin
               setH1_d = bus.cur_h1;
               setH0_d = bus.cur_h0;
               setM1_d = bus.cur_m1;
               setM0_d = bus.cur_m0;
               state_d = SET_HR;
            end
         end

         SET_HR, SET_MT, SET_MU: begin
            if (modeEv || timeoutHit) begin
               state_d = RUN;
            end else if (selEv) begin
               idle_d = 8'd0;
               if (state_q == SET_HR)
                  state_d = SET_MT;
               else if (state_q == SET_MT)
                  state_d = SET_MU;
               else
                  state_d = COMMIT;
            end else if (incEv) begin
               idle_d = 8'd0;
               if (state_q == SET_HR)
                  {setH1_d, setH0_d} = hourNext;
               else if (state_q == SET_MT)
                  setM1_d = bcd_wrap_inc(setM1_q, MIN_MAX_T);
               else
                  setM0_d = bcd_wrap_inc(setM0_q, DIG_MAX);
            end else if (bus.tick_1hz) begin
               idle_d = idle_q + 8'd1;
            end
         end

         COMMIT: begin
            state_d = RUN;
         end

         default: begin
            state_d = RUN;
         end
      endcase
   end

   assign bus.run_en   = (state_q == RUN);
   assign bus.load     = (state_q == COMMIT);
   assign bus.set_mode = (state_q != RUN);
   assign bus.set_h1   = setH1_q;
   assign bus.set_h0   = setH0_q;
   assign bus.set_m1   = setM1_q;
   assign bus.set_m0   = setM0_q;

`ifdef CLKSET_BLINK_EN
   localparam int BW = int'(BLINK_BIT) + 1;

   logic [BW-1:0] blinkDiv_q;
   logic [3:0]    blankPat;

   // Free-running divider; only its top bit is used as the blink phase.
   always_ff @(posedge pCLK or posedge pRST) begin
      if (pRST)
         blinkDiv_q <= '0;
      else
         blinkDiv_q <= blinkDiv_q + BW'(1);
   end

   // Blank only the field being edited, and only in the "off" blink phase.
   always_comb begin
      blankPat = 4'b0000;
      if (blinkDiv_q[BW-1]) begin
         case (state_q)
            SET_HR:  blankPat = 4'b1100;
            SET_MT:  blankPat = 4'b0010;
            SET_MU:  blankPat = 4'b0001;
            default: blankPat = 4'b0000;
         endcase
      end
   end

   assign bus.blank = blankPat;
`else
   assign bus.blank = 4'b0000;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_set_ctrl
// Directed bench for clock_set_ctrl with DB_CYCLES=4 and TIMEOUT_SEC=3.
// Buttons are held well past the debounce time and then released, so each
// press yields one event. Expected values are worked out by hand.
// ---------------------------------------------------------------------------
module tb_clock_set_ctrl;

   logic pCLK;
   logic pRST;
   int   errorCount;
   int   checkCount;

   // Monitor state
   int          loadCount;
   int          entryCount;
   logic [15:0] loadVal;
   logic        loadRunEn;
   logic        runAfterLoad;
   logic        prevLoad;
   logic        prevSetMode;

   clock_set_ctrl_if bus ();

   clock_set_ctrl #(
      .DB_CYCLES   (16'd4),
      .TIMEOUT_SEC (8'd3)
   ) dut (
      .pCLK (pCLK),
      .pRST (pRST),
      .bus  (bus)
   );

   // 10 ns clock
   initial begin
      pCLK = 1'b0;
      forever #5 pCLK = ~pCLK;
   end

   // Watch load pulses and set-mode entries on the falling edge, where all
   // DUT outputs are stable.
   always @(negedge pCLK) begin
      if (pRST) begin
         prevLoad    = 1'b0;
         prevSetMode = 1'b0;
      end else begin
         if (prevLoad)
            runAfterLoad = bus.run_en && !bus.load;
         if (bus.load) begin
            loadCount = loadCount + 1;
            loadVal   = {bus.set_h1, bus.set_h0, bus.set_m1, bus.set_m0};
            loadRunEn = bus.run_en;
         end
         if (bus.set_mode && !prevSetMode)
            entryCount = entryCount + 1;
         prevLoad    = bus.load;
         prevSetMode = bus.set_mode;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount = checkCount + 1;
      if (actual !== expected) begin
         errorCount = errorCount + 1;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Hold the given buttons long enough to be accepted, then release and let
   // the release settle before returning.
   task automatic applyStimulus(input logic m, input logic s, input logic i);
      @(posedge pCLK); #1;
      bus.btn_mode = m;
      bus.btn_sel  = s;
      bus.btn_inc  = i;
      repeat (10) @(posedge pCLK);
      #1;
      bus.btn_mode = 1'b0;
      bus.btn_sel  = 1'b0;
      bus.btn_inc  = 1'b0;
      repeat (10) @(posedge pCLK);
      #1;
   endtask

   task automatic applyTick();
      @(posedge pCLK); #1;
      bus.tick_1hz = 1'b1;
      @(posedge pCLK); #1;
      bus.tick_1hz = 1'b0;
      repeat (2) @(posedge pCLK);
      #1;
   endtask

   task automatic setCur(input logic [15:0] t);
      {bus.cur_h1, bus.cur_h0, bus.cur_m1, bus.cur_m0} = t;
   endtask

   function automatic logic [31:0] shadow();
      return {16'h0, bus.set_h1, bus.set_h0, bus.set_m1, bus.set_m0};
   endfunction

   initial begin
      int   loadsBefore;
      int   entriesBefore;
      logic sawOn;
      logic sawOff;
      logic sawOther;

      errorCount   = 0;
      checkCount   = 0;
      loadCount    = 0;
      entryCount   = 0;
      loadVal      = 16'h0;
      loadRunEn    = 1'b1;
      runAfterLoad = 1'b0;
      prevLoad     = 1'b0;
      prevSetMode  = 1'b0;
      bus.btn_mode = 1'b0;
      bus.btn_sel  = 1'b0;
      bus.btn_inc  = 1'b0;
      bus.tick_1hz = 1'b0;
      setCur(16'h0000);

      // Reset values
      pRST = 1'b1;
      repeat (3) @(posedge pCLK);
      #1;
      checkOutput("rst_run_en",   32'(bus.run_en),   32'd1);
      checkOutput("rst_load",     32'(bus.load),     32'd0);
      checkOutput("rst_set",      shadow(),          32'h0);
      checkOutput("rst_set_mode", 32'(bus.set_mode), 32'd0);
      checkOutput("rst_blank",    32'(bus.blank),    32'd0);
      pRST = 1'b0;
      repeat (3) @(posedge pCLK);
      #1;

      // 1: bouncing mode button gives exactly one event
      setCur(16'h0000);
      entriesBefore = entryCount;
      for (int k = 0; k < 3; k++) begin
         bus.btn_mode = 1'b1;
         repeat (2) @(posedge pCLK);
         #1;
         bus.btn_mode = 1'b0;
         repeat (2) @(posedge pCLK);
         #1;
      end
      checkOutput("bounce_no_early", 32'(bus.run_en), 32'd1);
      bus.btn_mode = 1'b1;
      repeat (10) @(posedge pCLK);
      #1;
      bus.btn_mode = 1'b0;
      repeat (10) @(posedge pCLK);
      #1;
      checkOutput("bounce_run_en",  32'(bus.run_en),   32'd0);
      checkOutput("bounce_setmode", 32'(bus.set_mode), 32'd1);
      checkOutput("bounce_entries", 32'(entryCount - entriesBefore), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("bounce_exit", 32'(bus.run_en), 32'd1);

      // 2: hour wrap
      setCur(16'h2247);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("hr_capture", shadow(), 32'h2247);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("hr_22_23", shadow(), 32'h2347);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("hr_23_00", shadow(), 32'h0047);
      applyStimulus(1'b1, 1'b0, 1'b0);
      setCur(16'h0915);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("hr_09_10", shadow(), 32'h1015);
      applyStimulus(1'b1, 1'b0, 1'b0);

      // 3: full commit 12:34 -> 12:59
      setCur(16'h1234);
      loadsBefore = loadCount;
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("commit_m1", shadow(), 32'h1254);
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++)
         applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("commit_m0",      shadow(), 32'h1259);
      checkOutput("commit_noload",  32'(loadCount - loadsBefore), 32'd0);
      checkOutput("commit_frozen",  32'(bus.run_en), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("commit_loads",   32'(loadCount - loadsBefore), 32'd1);
      checkOutput("commit_val",     32'(loadVal), 32'h1259);
      checkOutput("commit_run_low", 32'(loadRunEn), 32'd0);
      checkOutput("commit_run_nxt", 32'(runAfterLoad), 32'd1);
      checkOutput("commit_end_run", 32'(bus.run_en), 32'd1);

      // 4: abort from SET_MT, then idle timeout
      loadsBefore = loadCount;
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("abort_in_set", 32'(bus.run_en), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("abort_run", 32'(bus.run_en), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyTick();
      applyTick();
      checkOutput("tmo_2ticks", 32'(bus.run_en), 32'd0);
      applyTick();
      checkOutput("tmo_3ticks", 32'(bus.run_en), 32'd1);
      checkOutput("tmo_noload", 32'(loadCount - loadsBefore), 32'd0);

      // 5: simultaneous events
      setCur(16'h0800);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("sim_mode_sel", 32'(bus.run_en), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("sim_sel_inc", shadow(), 32'h0800);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("sim_in_mt", shadow(), 32'h0810);

      // 6: SET_MU, blink behaviour, then asynchronous reset
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("mu_inc", shadow(), 32'h0811);
      sawOn    = 1'b0;
      sawOff   = 1'b0;
      sawOther = 1'b0;
      for (int k = 0; k < 1100; k++) begin
         @(negedge pCLK);
         if (bus.blank == 4'b0001)
            sawOn = 1'b1;
         else if (bus.blank == 4'b0000)
            sawOff = 1'b1;
         else
            sawOther = 1'b1;
      end
`ifdef CLKSET_BLINK_EN
      checkOutput("blink_on",  32'(sawOn), 32'd1);
`else
      checkOutput("blank_tied", 32'(sawOn), 32'd0);
`endif
      checkOutput("blink_off",   32'(sawOff),   32'd1);
      checkOutput("blink_other", 32'(sawOther), 32'd0);
      checkOutput("mu_still_set", 32'(bus.set_mode), 32'd1);

      loadsBefore = loadCount;
      @(negedge pCLK);
      #2;
      pRST = 1'b1;
      #1;
      checkOutput("arst_run_en",   32'(bus.run_en),   32'd1);
      checkOutput("arst_load",     32'(bus.load),     32'd0);
      checkOutput("arst_set",      shadow(),          32'h0);
      checkOutput("arst_set_mode", 32'(bus.set_mode), 32'd0);
      checkOutput("arst_blank",    32'(bus.blank),    32'd0);
      repeat (2) @(posedge pCLK);
      #1;
      pRST = 1'b0;
      repeat (5) @(posedge pCLK);
      #1;
      checkOutput("arst_noload", 32'(loadCount - loadsBefore), 32'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
